// File: rtl/dma_dev_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM encoding for dma_fifo_device.
package dma_dev_pkg;

  localparam int REG_IDX_W = 3;

  localparam logic [REG_IDX_W-1:0] REG_START_ADDR = 3'd0;
  localparam logic [REG_IDX_W-1:0] REG_N_WORDS    = 3'd1;
  localparam logic [REG_IDX_W-1:0] REG_CTRL       = 3'd2;
  localparam logic [REG_IDX_W-1:0] REG_STATUS     = 3'd3;
  localparam logic [REG_IDX_W-1:0] REG_RX_DATA    = 3'd4;
  localparam logic [REG_IDX_W-1:0] REG_TX_DATA    = 3'd5;
  localparam logic [REG_IDX_W-1:0] REG_LEVEL      = 3'd6;

  localparam int CTRL_START = 0;
  localparam int CTRL_RD_WR = 2;
  localparam int CTRL_FLUSH = 5;
  localparam int CTRL_IE    = 6;

  localparam int ST_BUSY     = 0;
  localparam int ST_DONE     = 1;
  localparam int ST_ERROR    = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_RX_FULL  = 4;
  localparam int ST_TX_EMPTY = 5;
  localparam int ST_TX_FULL  = 6;
  localparam int ST_TX_OVF   = 7;
  localparam int ST_RX_UDF   = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/dma_fifo_device_fifo.sv
// Synchronous FIFO, 2^AW words deep; push when full and pop when empty are ignored.
module dma_sync_fifo #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == {1'b1, {AW{1'b0}}});
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // NOTE: storage is left unreset; only pointers and level define validity, and
  // readers gate the head word with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/dma_fifo_device.sv
// DMA peripheral on the per_* bus: config registers, transfer FSM and RX/TX FIFOs.
// Optional registered interrupt enabled by defining DMA_FIFO_DEV_IRQ_EN.
module dma_fifo_device
  import dma_dev_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR = 15'h0100,
  parameter int          DEC_WD    = 4,
  parameter int          FIFO_AW   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  input  logic [15:0] dev_in,
  input  logic        dma_ack,
  input  logic        dma_end_flag,
  input  logic        dma_error_flag,
  output logic [15:0] dev_out,
  output logic        dev_ack,
  output logic        dma_rqst,
  output logic        dma_rd_wr,
  output logic [15:0] dma_start_address,
  output logic [15:0] dma_num_words,
  output logic        irq
);

  state_e                 state;
  logic [15:0]            wcnt;
  logic [15:0]            wcnt_inc;
  logic                   done, error, tx_ovf, rx_udf, ie;
  logic                   running, xfer;
  logic                   reg_sel, reg_wr, reg_rd;
  logic [REG_IDX_W-1:0]   reg_idx;
  logic                   wr_ctrl, wr_status, start_cmd, flush_cmd;
  logic                   rx_push, rx_pop, rx_full, rx_empty;
  logic                   tx_push, tx_pop, tx_full, tx_empty;
  logic [15:0]            rx_dout, tx_dout;
  logic [FIFO_AW:0]       rx_level, tx_level;
  logic [15:0]            status;

  assign reg_sel   = per_en & (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_wr    = reg_sel & (|per_we);
  assign reg_rd    = reg_sel & ~(|per_we);
  assign reg_idx   = per_addr[REG_IDX_W-1:0];
  assign wr_ctrl   = reg_wr & (reg_idx == REG_CTRL);
  assign wr_status = reg_wr & (reg_idx == REG_STATUS);
  assign start_cmd = wr_ctrl & per_din[CTRL_START];
  assign flush_cmd = wr_ctrl & per_din[CTRL_FLUSH] & ~running;

  assign running  = (state == S_RUN);
  assign dma_rqst = running;
  assign dev_ack  = running & (dma_rd_wr ? ~rx_full : ~tx_empty);
  assign xfer     = dma_ack & dev_ack;
  assign wcnt_inc = wcnt + 16'd1;
  assign dev_out  = tx_empty ? 16'h0000 : tx_dout;

  assign rx_push = xfer & dma_rd_wr;
  assign tx_pop  = xfer & ~dma_rd_wr;
  assign rx_pop  = reg_rd & (reg_idx == REG_RX_DATA);
  assign tx_push = reg_wr & (reg_idx == REG_TX_DATA);

  dma_sync_fifo #(.DW(16), .AW(FIFO_AW)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .flush(flush_cmd),
    .din(dev_in), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  dma_sync_fifo #(.DW(16), .AW(FIFO_AW)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .flush(flush_cmd),
    .din(per_din), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  // Configuration registers; mode and length are frozen while a transfer runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dma_start_address <= '0;
      dma_num_words     <= '0;
      dma_rd_wr         <= 1'b0;
      ie                <= 1'b0;
      tx_ovf            <= 1'b0;
      rx_udf            <= 1'b0;
    end else begin
      if (reg_wr && reg_idx == REG_START_ADDR) dma_start_address <= per_din;
      if (reg_wr && reg_idx == REG_N_WORDS && !running) dma_num_words <= per_din;
      if (wr_ctrl) begin
        ie <= per_din[CTRL_IE];
        if (!running) dma_rd_wr <= per_din[CTRL_RD_WR];
      end
      if (wr_status && per_din[ST_TX_OVF]) tx_ovf <= 1'b0;
      if (wr_status && per_din[ST_RX_UDF]) rx_udf <= 1'b0;
      if (tx_push && tx_full)  tx_ovf <= 1'b1;
      if (rx_pop && rx_empty)  rx_udf <= 1'b1;
    end
  end

  // Transfer FSM; hardware set of done/error overrides a same-cycle W1C.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      wcnt  <= '0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      if (wr_status && per_din[ST_DONE])  done  <= 1'b0;
      if (wr_status && per_din[ST_ERROR]) error <= 1'b0;
      case (state)
        S_RUN: begin
          if (xfer) wcnt <= wcnt_inc;
          if (dma_error_flag) begin
            state <= S_ERR;
            error <= 1'b1;
          end else if (dma_end_flag || (xfer && wcnt_inc == dma_num_words)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start_cmd) begin
            error <= 1'b0;
            if (dma_num_words == 16'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              wcnt  <= '0;
              done  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

`ifdef DMA_FIFO_DEV_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= ie & (done | error | tx_ovf | rx_udf);
  end
`else
  assign irq = 1'b0;
`endif

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    status              = '0;
    status[ST_BUSY]     = running;
    status[ST_DONE]     = done;
    status[ST_ERROR]    = error;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_UDF]   = rx_udf;
  end

  always_comb begin
    per_dout = 16'h0000;
    if (reg_rd) begin
      case (reg_idx)
        REG_START_ADDR: per_dout = dma_start_address;
        REG_N_WORDS:    per_dout = dma_num_words;
        REG_CTRL:       per_dout = {9'd0, ie, 3'd0, dma_rd_wr, 2'd0};
        REG_STATUS:     per_dout = status;
        REG_RX_DATA:    per_dout = rx_empty ? 16'h0000 : rx_dout;
        REG_LEVEL:      per_dout = {8'(rx_level), 8'(tx_level)};
        default:        per_dout = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_fifo_device.sv
// Directed self-checking bench for dma_fifo_device (default FIFO_AW=3).
module tb_dma_fifo_device;

  localparam logic [14:0] BASE = 15'h0100;
  localparam logic [3:0] O_START = 4'h0, O_NW = 4'h2, O_CTRL = 4'h4, O_STAT = 4'h6,
                         O_RX = 4'h8, O_TX = 4'hA, O_LVL = 4'hC;
`ifdef DMA_FIFO_DEV_IRQ_EN
  localparam logic IRQ_EXP = 1'b1;
`else
  localparam logic IRQ_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] per_addr = '0;
  logic [15:0] per_din = '0;
  logic        per_en = 1'b0;
  logic [1:0]  per_we = '0;
  logic [15:0] per_dout;
  logic [15:0] dev_in = '0;
  logic        dma_ack = 1'b0;
  logic        dma_end_flag = 1'b0;
  logic        dma_error_flag = 1'b0;
  logic [15:0] dev_out;
  logic        dev_ack, dma_rqst, dma_rd_wr, irq;
  logic [15:0] dma_start_address, dma_num_words;

  int tests_run = 0;
  int tests_failed = 0;

  dma_fifo_device dut (
    .clk(clk), .reset(reset), .per_addr(per_addr), .per_din(per_din), .per_en(per_en),
    .per_we(per_we), .per_dout(per_dout), .dev_in(dev_in), .dma_ack(dma_ack),
    .dma_end_flag(dma_end_flag), .dma_error_flag(dma_error_flag), .dev_out(dev_out),
    .dev_ack(dev_ack), .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
    .dma_start_address(dma_start_address), .dma_num_words(dma_num_words), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [13:0] addr_of(input logic [3:0] off);
    logic [14:0] b;
    b = BASE + {11'd0, off};
    return b[14:1];
  endfunction

  task automatic bus_write(input logic [3:0] off, input logic [15:0] data);
    @(negedge clk);
    per_en = 1'b1; per_we = 2'b11; per_addr = addr_of(off); per_din = data;
    @(negedge clk);
    per_en = 1'b0; per_we = 2'b00;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [15:0] data);
    @(negedge clk);
    per_en = 1'b1; per_we = 2'b00; per_addr = addr_of(off);
    #1 data = per_dout;
    @(negedge clk);
    per_en = 1'b0;
  endtask

  task automatic dma_pulse(input logic [15:0] data);
    @(negedge clk);
    dma_ack = 1'b1; dev_in = data;
    @(negedge clk);
    dma_ack = 1'b0;
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk1("rst_rqst", dma_rqst, 1'b0);
    chk1("rst_dev_ack", dev_ack, 1'b0);
    chk16("rst_dev_out", dev_out, 16'h0000);
    chk1("rst_irq", irq, 1'b0);
    chk16("rst_per_dout", per_dout, 16'h0000);
    bus_read(O_STAT, v);
    chk16("rst_status", v, 16'h0028);
  endtask

  task automatic test_read_mode();
    logic [15:0] v;
    bus_write(O_NW, 16'd4);
    bus_write(O_CTRL, 16'h0005);
    chk1("rd_rqst", dma_rqst, 1'b1);
    chk1("rd_dev_ack", dev_ack, 1'b1);
    for (int i = 0; i < 4; i++) dma_pulse(16'h00A0 + 16'(i));
    bus_read(O_STAT, v);
    chk16("rd_status_done", v, 16'h0022);
    for (int i = 0; i < 4; i++) begin
      bus_read(O_RX, v);
      chk16("rd_rx_data", v, 16'h00A0 + 16'(i));
    end
    bus_read(O_RX, v);
    chk16("rd_rx_underflow_data", v, 16'h0000);
    bus_read(O_STAT, v);
    chk16("rd_status_udf", v, 16'h012A);
    bus_write(O_STAT, 16'h01FE);
    bus_read(O_STAT, v);
    chk16("rd_status_w1c", v, 16'h0028);
  endtask

  task automatic test_backpressure();
    logic [15:0] v;
    bus_write(O_NW, 16'd12);
    bus_write(O_CTRL, 16'h0005);
    for (int i = 0; i < 8; i++) dma_pulse(16'h0010 + 16'(i));
    chk1("bp_dev_ack_full", dev_ack, 1'b0);
    dma_pulse(16'hDEAD);
    dma_pulse(16'hBEEF);
    bus_read(O_LVL, v);
    chk16("bp_level", v, 16'h0800);
    bus_read(O_STAT, v);
    chk16("bp_status", v, 16'h0031);
    bus_read(O_RX, v);
    chk16("bp_pop_head", v, 16'h0010);
    chk1("bp_dev_ack_after_pop", dev_ack, 1'b1);
    @(negedge clk); dma_end_flag = 1'b1;
    @(negedge clk); dma_end_flag = 1'b0;
    bus_read(O_STAT, v);
    chk16("bp_end_flag_done", v, 16'h0022);
    bus_write(O_CTRL, 16'h0020);
    bus_read(O_LVL, v);
    chk16("bp_flush_level", v, 16'h0000);
  endtask

  task automatic test_write_mode();
    logic [15:0] v;
    bus_write(O_STAT, 16'h01FE);
    for (int k = 1; k <= 9; k++) bus_write(O_TX, 16'h1111 * 16'(k));
    chk16("wr_dev_out_head", dev_out, 16'h1111);
    bus_read(O_STAT, v);
    chk16("wr_status_ovf", v, 16'h00C8);
    bus_write(O_NW, 16'd3);
    bus_write(O_CTRL, 16'h0001);
    chk1("wr_rd_wr", dma_rd_wr, 1'b0);
    chk1("wr_dev_ack", dev_ack, 1'b1);
    dma_pulse(16'h0000);
    chk16("wr_dev_out_2", dev_out, 16'h2222);
    dma_pulse(16'h0000);
    chk16("wr_dev_out_3", dev_out, 16'h3333);
    dma_pulse(16'h0000);
    chk16("wr_dev_out_4", dev_out, 16'h4444);
    chk1("wr_done_no_ack", dev_ack, 1'b0);
    bus_read(O_LVL, v);
    chk16("wr_level", v, 16'h0005);
    bus_write(O_CTRL, 16'h0020);
    bus_write(O_STAT, 16'h01FE);
  endtask

  task automatic test_error_priority();
    logic [15:0] v;
    bus_write(O_NW, 16'd5);
    bus_write(O_CTRL, 16'h0041);
    chk1("err_running", dma_rqst, 1'b1);
    @(negedge clk); dma_error_flag = 1'b1; dma_end_flag = 1'b1;
    @(negedge clk); dma_error_flag = 1'b0; dma_end_flag = 1'b0;
    bus_read(O_STAT, v);
    chk16("err_status", v, 16'h002C);
    chk1("err_irq", irq, IRQ_EXP);
    bus_write(O_CTRL, 16'h0000);
    @(negedge clk);
    chk1("err_irq_masked", irq, 1'b0);
    bus_write(O_STAT, 16'h01FE);
  endtask

  task automatic test_zero_and_restart();
    logic [15:0] v;
    logic        saw_rqst;
    bus_write(O_NW, 16'd0);
    saw_rqst = 1'b0;
    fork
      bus_write(O_CTRL, 16'h0001);
      repeat (4) begin @(negedge clk); #1 saw_rqst = saw_rqst | dma_rqst; end
    join
    chk1("zero_no_rqst", saw_rqst, 1'b0);
    bus_read(O_STAT, v);
    chk16("zero_done", v, 16'h002A);
    bus_write(O_NW, 16'd4);
    bus_write(O_CTRL, 16'h0005);
    dma_pulse(16'h00B0);
    dma_pulse(16'h00B1);
    bus_write(O_CTRL, 16'h0001);
    chk1("rs_rqst_kept", dma_rqst, 1'b1);
    chk1("rs_rd_wr_kept", dma_rd_wr, 1'b1);
    dma_pulse(16'h00B2);
    dma_pulse(16'h00B3);
    bus_read(O_STAT, v);
    chk16("rs_done_after_4", v, 16'h0022);
    bus_write(O_STAT, 16'h0002);
    bus_read(O_STAT, v);
    chk16("rs_done_w1c", v, 16'h0020);
    bus_write(O_CTRL, 16'h0020);
  endtask

  task automatic test_reset_mid_transfer();
    logic [15:0] v;
    bus_write(O_START, 16'h1234);
    chk16("mr_start_addr", dma_start_address, 16'h1234);
    bus_write(O_NW, 16'd10);
    bus_write(O_CTRL, 16'h0005);
    for (int i = 0; i < 3; i++) dma_pulse(16'h00C0 + 16'(i));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk1("mr_rqst_async", dma_rqst, 1'b0);
    chk1("mr_dev_ack", dev_ack, 1'b0);
    chk16("mr_start_cleared", dma_start_address, 16'h0000);
    chk16("mr_nwords_cleared", dma_num_words, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    bus_read(O_STAT, v);
    chk16("mr_status", v, 16'h0028);
    bus_read(O_LVL, v);
    chk16("mr_level", v, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_read_mode();
    test_backpressure();
    test_write_mode();
    test_error_priority();
    test_zero_and_restart();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
